// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder: symbol codes, word geometry,
// FSM state encoding and the dot/dash classifier.
package morse_pkg;

    localparam int SYM_W  = 2;
    localparam int SLOTS  = 5;
    localparam int WORD_W = 10;

    // 10 is reserved and never produced.
    localparam logic [SYM_W-1:0] SYM_NONE = 2'b00;
    localparam logic [SYM_W-1:0] SYM_DOT  = 2'b01;
    localparam logic [SYM_W-1:0] SYM_DASH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_GAP    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // A press shorter than dash_ticks is a dot, otherwise a dash.
    function automatic logic [SYM_W-1:0] classify(input logic [2:0] ticks, input int dash_ticks);
        return (int'(ticks) < dash_ticks) ? SYM_DOT : SYM_DASH;
    endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Key/commit inputs, tick strobe and code-word outputs of the Morse encoder.
interface morse_encoder_if;
    import morse_pkg::*;

    logic              tick;
    logic              key_n;
    logic              next_n;
    logic [WORD_W-1:0] q;
    logic              q_valid;
    logic [2:0]        sym_count;
    logic              overflow;

    modport master (output tick, key_n, next_n,
                    input  q, q_valid, sym_count, overflow);
    modport slave  (input  tick, key_n, next_n,
                    output q, q_valid, sym_count, overflow);

endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer for an active-low raw button plus a one-cycle
// pulse on its (synchronized) falling edge. Flops reset to the released level
// so no spurious press is reported coming out of reset.
module key_sync (
    input  logic clock,
    input  logic resetn,
    input  logic i_raw_n,
    output logic o_held,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_raw_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_held = ~r_s2;
    assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/morse_encoder.sv
// Morse key encoder: times presses in ticks, classifies dot/dash, packs up to
// five symbols into a 10-bit word (oldest symbol in the highest occupied slot)
// and commits it with a one-cycle q_valid strobe.
// Optional feature: define MORSE_AUTO_COMMIT_EN to commit automatically after
// GAP_TICKS idle ticks following the last symbol.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int DASH_TICKS = 3,
    parameter int GAP_TICKS  = 7
) (
    input  logic            clock,
    input  logic            resetn,
    morse_encoder_if.slave  bus
);

    // Counters saturate at 7 (press) and 15 (gap); larger thresholds could never fire.
    if (DASH_TICKS < 1 || DASH_TICKS > 7 || GAP_TICKS < 1 || GAP_TICKS > 15) begin : g_bad_cfg
        $error("morse_encoder: tick threshold outside counter range");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_press_cnt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_q;
    logic [2:0]        r_sym_cnt;
    logic              r_ovf;
    logic              r_pending;
    logic              r_q_valid;

    logic w_key_held;
    logic w_key_fall;
    logic w_next_fall;
    logic w_next_held_unused;
    logic w_full;
    logic w_has_sym;
    logic w_gap_done;
    logic w_commit_req;

    key_sync u_key_sync (
        .clock   (clock),
        .resetn  (resetn),
        .i_raw_n (bus.key_n),
        .o_held  (w_key_held),
        .o_fall  (w_key_fall)
    );

    key_sync u_next_sync (
        .clock   (clock),
        .resetn  (resetn),
        .i_raw_n (bus.next_n),
        .o_held  (w_next_held_unused),
        .o_fall  (w_next_fall)
    );

    assign w_full    = (r_sym_cnt == 3'(SLOTS));
    assign w_has_sym = (r_sym_cnt != 3'd0);

`ifdef MORSE_AUTO_COMMIT_EN
    logic [3:0] r_gap_cnt;

    // Idle ticks since the last symbol; zero whenever the FSM is not in GAP.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_gap_cnt <= '0;
        end else if (r_state != ST_GAP) begin
            r_gap_cnt <= '0;
        end else if (bus.tick && r_gap_cnt != 4'hF) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
        end
    end

    assign w_gap_done = (r_state == ST_GAP) && (r_gap_cnt == 4'(GAP_TICKS));
`else
    assign w_gap_done = 1'b0;
`endif

    // Only consulted in IDLE/GAP; an empty word never commits.
    assign w_commit_req = (w_next_fall || w_gap_done) && w_has_sym;

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; a new press beats a simultaneous commit request
    // (a coincident next edge is kept as pending instead).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_key_fall)        w_state_nxt = ST_PRESS;
                else if (w_commit_req) w_state_nxt = ST_COMMIT;
            end
            ST_PRESS: begin
                if (!w_key_held)
                    w_state_nxt = (r_pending || w_next_fall) ? ST_COMMIT : ST_GAP;
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Press timing, symbol assembly, overflow tracking and word commit.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_press_cnt <= '0;
            r_word      <= '0;
            r_q         <= '0;
            r_sym_cnt   <= '0;
            r_ovf       <= 1'b0;
            r_pending   <= 1'b0;
            r_q_valid   <= 1'b0;
        end else begin
            r_q_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_key_fall) begin
                        r_press_cnt <= '0;
                        r_pending   <= w_next_fall && w_has_sym;
                    end
                end
                ST_PRESS: begin
                    if (w_key_held) begin
                        if (bus.tick && r_press_cnt != 3'd7) r_press_cnt <= r_press_cnt + 3'd1;
                        if (w_next_fall)                     r_pending   <= 1'b1;
                    end else begin
                        // Release: the count excludes any tick in this same cycle.
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_word    <= {r_word[WORD_W-SYM_W-1:0], classify(r_press_cnt, DASH_TICKS)};
                            r_sym_cnt <= r_sym_cnt + 3'd1;
                        end
                        r_pending <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    r_q       <= r_word;
                    r_q_valid <= 1'b1;
                    r_word    <= {SLOTS{SYM_NONE}};
                    r_sym_cnt <= '0;
                    r_ovf     <= 1'b0;
                    r_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.q         = r_q;
    assign bus.q_valid   = r_q_valid;
    assign bus.sym_count = r_sym_cnt;
    assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder: directed scenarios plus randomized
// words checked against a symbol-list model of the packed code word.
module tb_morse_encoder;

    localparam int DASH = 3;

    logic clock = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    int           model_q[$];
    int           n_valid    = 0;
    int           wide_pulse = 0;
    logic         prev_v     = 1'b0;
    logic [9:0]   last_q     = '0;

    morse_encoder_if bus();

    morse_encoder #(.DASH_TICKS(DASH), .GAP_TICKS(7)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Record every commit strobe and any strobe wider than one cycle.
    always @(negedge clock) begin
        if (bus.q_valid === 1'b1) begin
            n_valid <= n_valid + 1;
            last_q  <= bus.q;
            if (prev_v) wide_pulse <= wide_pulse + 1;
        end
        prev_v <= bus.q_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expected word: first five symbols, oldest in the most significant slot.
    function automatic logic [9:0] exp_word();
        int k = (model_q.size() > 5) ? 5 : model_q.size();
        int w = 0;
        for (int i = 0; i < k; i++) w = w * 4 + model_q[i];
        return 10'(w);
    endfunction

    // One key press lasting nt ticks with random spacing; updates the model.
    task automatic press_key(input int nt);
        int eff;
        bus.key_n = 1'b0;
        cyc(4);
        for (int i = 0; i < nt; i++) begin
            bus.tick = 1'b1;
            cyc(1);
            bus.tick = 1'b0;
            cyc($urandom_range(0, 2));
        end
        bus.key_n = 1'b1;
        cyc(4);
        eff = (nt > 7) ? 7 : nt;
        model_q.push_back((eff >= DASH) ? 3 : 1);
    endtask

    task automatic pulse_next();
        bus.next_n = 1'b0;
        cyc(2);
        bus.next_n = 1'b1;
        cyc(6);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.key_n = 1'b1; bus.next_n = 1'b1; bus.tick = 1'b0;
        cyc(3);
        checks++; if (bus.q !== 10'd0)        begin errors++; $display("FAIL reset_q got=%h exp=0", bus.q); end
        checks++; if (bus.q_valid !== 1'b0)   begin errors++; $display("FAIL reset_qv got=%b exp=0", bus.q_valid); end
        checks++; if (bus.sym_count !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.sym_count); end
        checks++; if (bus.overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
        resetn = 1'b1;
        cyc(2);
    endtask

    task automatic test_single_dot();
        int nv0 = n_valid;
        bus.key_n = 1'b0;
        cyc(4);
        bus.tick = 1'b1; cyc(1); bus.tick = 1'b0;
        bus.key_n = 1'b1;
        cyc(2);
        checks++; if (bus.sym_count !== 3'd0) begin errors++; $display("FAIL dot_cnt_early got=%0d exp=0", bus.sym_count); end
        cyc(1);
        checks++; if (bus.sym_count !== 3'd1) begin errors++; $display("FAIL dot_cnt_append got=%0d exp=1", bus.sym_count); end
        cyc(2);
        bus.next_n = 1'b0; cyc(2); bus.next_n = 1'b1;
        cyc(1);
        checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL dot_qv_early got=%b exp=0", bus.q_valid); end
        cyc(1);
        checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL dot_qv got=%b exp=1", bus.q_valid); end
        checks++; if (bus.q !== 10'b0000000001) begin errors++; $display("FAIL dot_q got=%b exp=0000000001", bus.q); end
        checks++; if (bus.sym_count !== 3'd0) begin errors++; $display("FAIL dot_cnt_clr got=%0d exp=0", bus.sym_count); end
        cyc(1);
        checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL dot_qv_width got=%b exp=0", bus.q_valid); end
        cyc(2);
        checks++; if (n_valid - nv0 !== 1) begin errors++; $display("FAIL dot_nvalid got=%0d exp=1", n_valid - nv0); end
    endtask

    task automatic test_sequence();
        int nv0 = n_valid;
        model_q.delete();
        press_key(4); press_key(1); press_key(5);
        checks++; if (bus.sym_count !== 3'd3) begin errors++; $display("FAIL seq_cnt got=%0d exp=3", bus.sym_count); end
        pulse_next();
        checks++; if (n_valid - nv0 !== 1) begin errors++; $display("FAIL seq_nvalid got=%0d exp=1", n_valid - nv0); end
        checks++; if (last_q !== 10'b0000110111) begin errors++; $display("FAIL seq_q got=%b exp=0000110111", last_q); end
        checks++; if (last_q !== exp_word()) begin errors++; $display("FAIL seq_model got=%b exp=%b", last_q, exp_word()); end
    endtask

    task automatic test_overflow();
        model_q.delete();
        for (int i = 0; i < 5; i++) press_key(1);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_five got=%b exp=0", bus.overflow); end
        press_key(1);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_six got=%b exp=1", bus.overflow); end
        checks++; if (bus.sym_count !== 3'd5) begin errors++; $display("FAIL ovf_cnt got=%0d exp=5", bus.sym_count); end
        pulse_next();
        checks++; if (last_q !== 10'b0101010101) begin errors++; $display("FAIL ovf_q got=%b exp=0101010101", last_q); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_pending();
        bus.key_n = 1'b0;
        cyc(4);
        bus.tick = 1'b1; cyc(3); bus.tick = 1'b0;
        bus.next_n = 1'b0; cyc(2); bus.next_n = 1'b1;
        cyc(3);
        checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL pend_held_qv got=%b exp=0", bus.q_valid); end
        bus.key_n = 1'b1;
        cyc(3);
        checks++; if (bus.sym_count !== 3'd1) begin errors++; $display("FAIL pend_cnt got=%0d exp=1", bus.sym_count); end
        cyc(1);
        checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL pend_qv got=%b exp=1", bus.q_valid); end
        checks++; if (bus.q !== 10'b0000000011) begin errors++; $display("FAIL pend_q got=%b exp=0000000011", bus.q); end
        cyc(4);
    endtask

    task automatic test_empty_next();
        int nv0 = n_valid;
        pulse_next();
        checks++; if (n_valid - nv0 !== 0) begin errors++; $display("FAIL empty_next got=%0d exp=0", n_valid - nv0); end
    endtask

    task automatic test_gap();
        int nv0;
        model_q.delete();
        press_key(1);
        nv0 = n_valid;
`ifdef MORSE_AUTO_COMMIT_EN
        for (int i = 0; i < 6; i++) begin bus.tick = 1'b1; cyc(1); bus.tick = 1'b0; cyc(1); end
        cyc(4);
        checks++; if (n_valid - nv0 !== 0) begin errors++; $display("FAIL gap_six got=%0d exp=0", n_valid - nv0); end
        bus.tick = 1'b1; cyc(1); bus.tick = 1'b0;
        cyc(5);
        checks++; if (n_valid - nv0 !== 1) begin errors++; $display("FAIL gap_auto got=%0d exp=1", n_valid - nv0); end
        checks++; if (last_q !== 10'b0000000001) begin errors++; $display("FAIL gap_q got=%b exp=0000000001", last_q); end
`else
        for (int i = 0; i < 20; i++) begin bus.tick = 1'b1; cyc(1); bus.tick = 1'b0; cyc(1); end
        cyc(4);
        checks++; if (n_valid - nv0 !== 0) begin errors++; $display("FAIL gap_noauto got=%0d exp=0", n_valid - nv0); end
        checks++; if (bus.sym_count !== 3'd1) begin errors++; $display("FAIL gap_cnt got=%0d exp=1", bus.sym_count); end
        pulse_next();
        checks++; if (last_q !== 10'b0000000001) begin errors++; $display("FAIL gap_q got=%b exp=0000000001", last_q); end
`endif
    endtask

    task automatic test_reset_mid();
        int nv0;
        model_q.delete();
        press_key(1); press_key(4);
        bus.key_n = 1'b0;
        cyc(4);
        bus.tick = 1'b1; cyc(2); bus.tick = 1'b0;
        bus.next_n = 1'b0; cyc(2); bus.next_n = 1'b1;
        cyc(3);
        nv0 = n_valid;
        resetn = 1'b0; bus.key_n = 1'b1;
        cyc(1);
        resetn = 1'b1;
        cyc(1);
        checks++; if (bus.sym_count !== 3'd0) begin errors++; $display("FAIL rmid_cnt got=%0d exp=0", bus.sym_count); end
        checks++; if (bus.overflow !== 1'b0)  begin errors++; $display("FAIL rmid_ovf got=%b exp=0", bus.overflow); end
        checks++; if (bus.q !== 10'd0)        begin errors++; $display("FAIL rmid_q got=%b exp=0", bus.q); end
        cyc(8);
        checks++; if (n_valid - nv0 !== 0) begin errors++; $display("FAIL rmid_qv got=%0d exp=0", n_valid - nv0); end
        model_q.delete();
        press_key(5);
        pulse_next();
        checks++; if (last_q !== 10'b0000000011) begin errors++; $display("FAIL rmid_fresh got=%b exp=0000000011", last_q); end
    endtask

    task automatic test_random();
        for (int w = 0; w < 8; w++) begin
            int n = $urandom_range(1, 7);
            int nv0 = n_valid;
            int ec;
            model_q.delete();
            for (int s = 0; s < n; s++) press_key($urandom_range(0, 9));
            ec = (n > 5) ? 5 : n;
            checks++; if (bus.sym_count !== 3'(ec)) begin errors++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", w, bus.sym_count, ec); end
            checks++; if (bus.overflow !== (n > 5)) begin errors++; $display("FAIL rnd%0d_ovf got=%b exp=%b", w, bus.overflow, n > 5); end
            pulse_next();
            checks++; if (n_valid - nv0 !== 1) begin errors++; $display("FAIL rnd%0d_nvalid got=%0d exp=1", w, n_valid - nv0); end
            checks++; if (last_q !== exp_word()) begin errors++; $display("FAIL rnd%0d_q got=%b exp=%b", w, last_q, exp_word()); end
            checks++; if (bus.sym_count !== 3'd0) begin errors++; $display("FAIL rnd%0d_clr got=%0d exp=0", w, bus.sym_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single_dot();
        test_sequence();
        test_overflow();
        test_pending();
        test_empty_next();
        test_gap();
        test_reset_mid();
        test_random();
        checks++; if (wide_pulse !== 0) begin errors++; $display("FAIL qv_width got=%0d exp=0", wide_pulse); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
